sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 169 ++++++++++++++++
 tb/tb_sha256_padder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_padder
// Description : Collects a byte stream into 512-bit SHA-256 message blocks and
//               appends the standard padding (0x80, zero fill, 64-bit
//               big-endian bit length), adding an extra length block when the
//               padding does not fit in the final data block.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in_valid/in_ready - byte input handshake
//               in_data, in_last  - message byte and end-of-message marker
//               blk_valid/blk_ready - block output handshake
//               blk_data          - block, byte 0 at [511:504]
//               blk_first         - first block of a message (default IV)
//               blk_last          - final block of a message
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_padder (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_first,
   output logic         blk_last
);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_PAD    = 2'd1,
      S_EMIT   = 2'd2,
      S_LENBLK = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [6:0]     idx_q, idx_d;
   logic [60:0]    cnt_q, cnt_d;
   logic           first_q, first_d;
   logic           last_q, last_d;
   logic           pend_len_q, pend_len_d;
   logic           pad_at0_q, pad_at0_d;
   logic [511:0]   buf_q, buf_d;
   logic [63:0]    w_len_bits;

   // Bit count wraps modulo 2^64 naturally from the 61-bit byte count.
   assign w_len_bits = {cnt_q, 3'b000};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FILL;
         idx_q      <= 7'd0;
         cnt_q      <= 61'd0;
         first_q    <= 1'b1;
         last_q     <= 1'b0;
         pend_len_q <= 1'b0;
         pad_at0_q  <= 1'b0;
         buf_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         last_q     <= last_d;
         pend_len_q <= pend_len_d;
         pad_at0_q  <= pad_at0_d;
         buf_q      <= buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      last_d     = last_q;
      pend_len_d = pend_len_q;
      pad_at0_d  = pad_at0_q;
      buf_d      = buf_q;

      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               for (int i = 0; i < 64; i++) begin
                  if (idx_q == 7'(i)) begin
                     buf_d[511 - 8*i -: 8] = in_data;
                  end
               end
               idx_d = idx_q + 7'd1;
               cnt_d = cnt_q + 61'd1;
               if (in_last) begin
                  state_d = S_PAD;
               end else if (idx_q == 7'd63) begin
                  state_d = S_EMIT;
                  last_d  = 1'b0;
               end
            end
         end

         S_PAD: begin
            state_d = S_EMIT;
            if (idx_q[6]) begin
               // Block is full of data: the 0x80 marker moves to the length block.
               last_d     = 1'b0;
               pend_len_d = 1'b1;
               pad_at0_d  = 1'b1;
            end else begin
               // Bytes past idx may hold a previous message's data, so they are
               // explicitly zeroed rather than assumed clear.
               for (int i = 0; i < 64; i++) begin
                  if (idx_q == 7'(i)) begin
                     buf_d[511 - 8*i -: 8] = 8'h80;
                  end else if (7'(i) > idx_q) begin
                     buf_d[511 - 8*i -: 8] = 8'h00;
                  end
               end
               if (idx_q <= 7'd55) begin
                  buf_d[63:0] = w_len_bits;
                  last_d      = 1'b1;
               end else begin
                  last_d     = 1'b0;
                  pend_len_d = 1'b1;
               end
            end
         end

         S_EMIT: begin
            if (blk_ready) begin
               if (pend_len_q) begin
                  pend_len_d = 1'b0;
                  first_d    = 1'b0;
                  state_d    = S_LENBLK;
               end else if (last_q) begin
                  idx_d   = 7'd0;
                  cnt_d   = 61'd0;
                  first_d = 1'b1;
                  state_d = S_FILL;
               end else begin
                  idx_d   = 7'd0;
                  buf_d   = '0;
                  first_d = 1'b0;
                  state_d = S_FILL;
               end
            end
         end

         S_LENBLK: begin
            buf_d          = '0;
            buf_d[511:504] = pad_at0_q ? 8'h80 : 8'h00;
            buf_d[63:0]    = w_len_bits;
            last_d         = 1'b1;
            pad_at0_d      = 1'b0;
            state_d        = S_EMIT;
         end

         default: state_d = S_FILL;
      endcase
   end

   assign in_ready  = (state_q == S_FILL);
   assign blk_valid = (state_q == S_EMIT);
   assign blk_data  = blk_valid ? buf_q : 512'd0;
   assign blk_first = blk_valid & first_q;
   assign blk_last  = blk_valid & last_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_padder
// Description : Scoreboard bench for sha256_padder. Stimulus pushes the
//               hand-computed expected blocks; a monitor pops and compares on
//               every block handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_padder;

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         last;
   } blk_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;

   blk_t exp_q[$];
   int   n_checks;
   int   n_pass;

   sha256_padder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Monitor: a handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && blk_valid && blk_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_block", 512'(blk_data), 512'(0));
            if (blk_data == 512'd0) begin
               n_pass--;
               $display("FAIL unexpected_block: got a block expected none");
            end
         end else begin
            blk_t e;
            e = exp_q.pop_front();
            chk("blk_data",  blk_data,        e.data);
            chk("blk_first", 512'(blk_first), 512'(e.first));
            chk("blk_last",  512'(blk_last),  512'(e.last));
         end
      end
   end

   task automatic push(input logic [511:0] d, input logic f, input logic l);
      blk_t e;
      e.data = d; e.first = f; e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int t;
      in_valid = 1'b1; in_data = d; in_last = l; t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            break;
         end
         t++;
         if (t > 200) begin
            chk("send_timeout", 512'(0), 512'(1));
            break;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_n(input int n, input logic [7:0] d);
      for (int i = 0; i < n; i++) send_byte(d, (i == n - 1));
   endtask

   task automatic send_abc;
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, 1'b1);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk); #1; t++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(name, 512'(exp_q.size()), 512'(0));
      exp_q.delete();
   endtask

   logic [511:0] e_abc, e_55, e_56a, e_56b, e_64a, e_64b;

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b1;

      e_abc = '0; e_abc[511:480] = 32'h61626380; e_abc[63:0] = 64'h18;
      e_55  = '0; e_55[71:64] = 8'h80;  e_55[63:0] = 64'h1B8;
      e_56a = '0; e_56a[63:56] = 8'h80;
      e_56b = '0; e_56b[63:0] = 64'h1C0;
      e_64a = {64{8'h41}};
      e_64b = '0; e_64b[511:504] = 8'h80; e_64b[63:0] = 64'h200;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  512'(in_ready),  512'(1));
      chk("rst_blk_valid", 512'(blk_valid), 512'(0));
      chk("rst_blk_first", 512'(blk_first), 512'(0));
      chk("rst_blk_last",  512'(blk_last),  512'(0));
      chk("rst_blk_data",  blk_data,        512'(0));
      @(posedge clk); #1;

      // "abc"
      push(e_abc, 1'b1, 1'b1);
      send_abc();
      drain("abc_drain");

      // 55 zero bytes: padding and length fit in one block
      push(e_55, 1'b1, 1'b1);
      send_n(55, 8'h00);
      drain("z55_drain");

      // 56 zero bytes: length spills into a second block
      push(e_56a, 1'b1, 1'b0);
      push(e_56b, 1'b0, 1'b1);
      send_n(56, 8'h00);
      drain("z56_drain");

      // 64 bytes of 0x41: 0x80 lands at byte 0 of the length block
      push(e_64a, 1'b1, 1'b0);
      push(e_64b, 1'b0, 1'b1);
      send_n(64, 8'h41);
      drain("a64_drain");

      // "abc" with downstream back-pressure
      blk_ready = 1'b0;
      push(e_abc, 1'b1, 1'b1);
      send_abc();
      begin
         int t;
         t = 0;
         while (!blk_valid && t < 50) begin @(negedge clk); t++; end
         chk("stall_valid_rise", 512'(blk_valid), 512'(1));
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("stall_valid",    512'(blk_valid), 512'(1));
         chk("stall_data",     blk_data,        e_abc);
         chk("stall_in_ready", 512'(in_ready),  512'(0));
      end
      @(posedge clk); #1 blk_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_one_handshake", 512'(blk_valid), 512'(0));
      drain("stall_drain");

      // Reset after 30 bytes discards the partial message
      for (int i = 0; i < 30; i++) send_byte(8'h55, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_in_ready",  512'(in_ready),  512'(1));
      chk("async_rst_blk_valid", 512'(blk_valid), 512'(0));
      @(posedge clk); #1 rst = 1'b0;
      push(e_abc, 1'b1, 1'b1);
      send_abc();
      drain("rst_abc_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
